seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream consumer of the stopwatch/clock BCD digit outputs; drives the board's 4-digit common-anode seven-segment display.
- Time-multiplexes the four digits at a programmable refresh rate and decodes BCD to segments.
- Snapshots all four digits once per frame so a digit never tears mid-frame.
- Drives the minutes/seconds separator dot, steady or blinking.

Parameters:
- REFRESH_DIV, 100000, clk100MHz cycles per digit slot (1 kHz per digit, 250 Hz frame).
- BLINK_DIV, 50000000, clk100MHz cycles per separator-dot half-period (0.5 s).
- BLANK_LEAD, 1, 1 = blank the ten-minutes digit when its snapshot value is 0.

Ports:
- clk100MHz  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- tenminout  in  4  BCD ten-minutes digit.
- oneminout  in  4  BCD one-minutes digit.
- tensecout  in  4  BCD ten-seconds digit.
- onesecout  in  4  BCD one-seconds digit.
- dp_blink  in  1  1 = separator dot blinks; 0 = dot steady on.
- seg  out  7  cathodes, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal-point cathode, active-low.
- an  out  4  anodes, active-low; an[0]=onesec, an[1]=tensec, an[2]=onemin, an[3]=tenmin.

Behaviour:
- Reset (async, while rst=1): an=4'b1111, seg=7'b1111111, dp=1. Prescaler, blink counter, digit index and snapshot registers all 0. frame_valid=0, blink_phase=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick=1 for the single cycle where count==REFRESH_DIV-1.
- Digit index (2-bit):
  - Increments on tick; 3→0 wraps.
  - Slot k drives an[k].
- Snapshot:
  - On the tick where index wraps 3→0, all four inputs are latched together and frame_valid is set to 1.
  - Inputs changing at any other time have no effect until the next wrap.
- Blank until first frame: while frame_valid=0, an=4'b1111 regardless of index. The first lit output follows the first 3→0 wrap, 4*REFRESH_DIV cycles after reset release.
- Outputs are registered: an/seg/dp reflect the new index exactly 1 clock after the tick cycle.
  - Exactly one an bit is low at a time; never two.
- Decode (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Non-BCD 10–15 → dash 0111111.
- Leading blank: if BLANK_LEAD=1, index=3 and snapshot tenmin==0 → an stays 4'b1111 for that slot and seg=7'b1111111. The one-minutes digit is never blanked.
- Separator dot:
  - dp=0 only in slot 2 (onemin).
  - When dp_blink=0: dp=0 in slot 2.
  - When dp_blink=1: dp=0 in slot 2 only while blink_phase=1.
  - Blink counter counts 0..BLINK_DIV-1 continuously and toggles blink_phase on its wrap, independent of the prescaler.
- Simultaneous events: snapshot load and output update on the same tick use the newly latched value for slot 0 in the following cycle.
- Reset mid-frame: immediate blank (async). The frame restarts from index 0 with frame_valid=0.

Test Plan (bench parameters: REFRESH_DIV=4, BLINK_DIV=16):
- Reset release, digits 1,2,3,4 (tenmin..onesec):
  - an=1111 for the first 16 cycles.
  - Then an cycles 1110,1101,1011,0111 with seg 0011001,0110000,0100100,1111001, 4 clocks each.
- Tear check: change onesec 4→7 while index=1 → slot 0 still shows 4 (0011001) until the next 3→0 wrap, then 7 (1111000).
- Leading blank: digits 0,5,0,9 → slot 3 has an=1111 and seg=1111111; slot 2 shows 5 (0010010), not blanked. Repeat with BLANK_LEAD=0 → slot 3 shows 0 (1000000).
- Non-BCD: onemin=4'hC → slot 2 seg=0111111.
- Separator dot:
  - dp_blink=0 → dp=0 in every slot-2 period, dp=1 in all other slots.
  - dp_blink=1 → dp=0 in slot 2 only during alternate 16-cycle windows.
- Async reset asserted mid-slot-2 → an=1111, seg=1111111, dp=1 in the same cycle. After release, the blank period repeats for 16 cycles.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Scans four BCD digits onto a common-anode 7-segment display, with a per-frame snapshot and a separator dot.
// Latency: an/seg/dp are registered and follow a slot change one clock after the prescaler tick.
// Backpressure: none; the digit inputs are sampled only at the frame boundary and are never stalled.
//
// Ports:
//   clk100MHz  - system clock (only clock)
//   rst        - asynchronous active-high reset; blanks the display immediately
//   tenminout, oneminout, tensecout, onesecout - BCD digits from the time source
//   dp_blink   - 1: separator dot blinks with the blink counter, 0: dot steady on
//   seg[6:0]   - segment cathodes, active-low, seg[0]=a .. seg[6]=g
//   dp         - decimal-point cathode, active-low
//   an[3:0]    - digit anodes, active-low, an[0]=onesec .. an[3]=tenmin
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input  logic       clk100MHz,
    input  logic       rst,
    input  logic [3:0] tenminout,
    input  logic [3:0] oneminout,
    input  logic [3:0] tensecout,
    input  logic [3:0] onesecout,
    input  logic       dp_blink,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Segment patterns, active-low, bit order gfedcba.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b0111111; // non-BCD shows a dash
        endcase
        return pat;
    endfunction

    logic [PW-1:0]     pre_q, pre_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][3:0]   snap_q, snap_d;    // [0]=onesec .. [3]=tenmin
    logic              frame_valid_q, frame_valid_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              tick;
    logic              frame_wrap;
    logic              blink_wrap;
    logic [3:0]        digit;

    always_comb begin
        tick          = (pre_q == PRE_LAST);
        pre_d         = tick ? '0 : pre_q + PW'(1);

        // Blink timebase runs free of the prescaler.
        blink_wrap    = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q ^ blink_wrap;

        idx_d         = tick ? idx_q + 2'd1 : idx_q;

        // All four digits are captured together at the 3->0 wrap so a frame never mixes old and new time.
        frame_wrap    = tick && (idx_q == 2'd3);
        snap_d        = frame_wrap ? {tenminout, oneminout, tensecout, onesecout} : snap_q;
        frame_valid_d = frame_valid_q | frame_wrap;

        // Outputs are computed from next-state values so the slot change and a fresh snapshot
        // appear together one clock after the tick.
        digit = snap_d[idx_d];
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (frame_valid_d) begin
            if (!(BLANK_LEAD && (idx_d == 2'd3) && (digit == 4'd0))) begin
                an_d  = ~(4'b0001 << idx_d);
                seg_d = seg_decode(digit);
            end
            if ((idx_d == 2'd2) && (!dp_blink || blink_phase_d)) begin
                dp_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            pre_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            idx_q         <= 2'd0;
            snap_q        <= '0;
            frame_valid_q <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= 7'b1111111;
            dp_q          <= 1'b1;
        end else begin
            pre_q         <= pre_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            frame_valid_q <= frame_valid_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (leading blank on/off) share stimulus.
// The reference derives every output from the clock count since reset release.
module tb_seg7_scan_driver;

    localparam int RD = 4;
    localparam int BD = 16;
    localparam int FRAME = 4 * RD;

    logic       clk100MHz = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tenminout = 4'd1;
    logic [3:0] oneminout = 4'd2;
    logic [3:0] tensecout = 4'd3;
    logic [3:0] onesecout = 4'd4;
    logic       dp_blink = 1'b0;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD), .BLANK_LEAD(1'b1)) dut_a (
        .clk100MHz(clk100MHz), .rst(rst),
        .tenminout(tenminout), .oneminout(oneminout),
        .tensecout(tensecout), .onesecout(onesecout),
        .dp_blink(dp_blink), .seg(seg_a), .dp(dp_a), .an(an_a)
    );

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD), .BLANK_LEAD(1'b0)) dut_b (
        .clk100MHz(clk100MHz), .rst(rst),
        .tenminout(tenminout), .oneminout(oneminout),
        .tensecout(tensecout), .onesecout(onesecout),
        .dp_blink(dp_blink), .seg(seg_b), .dp(dp_b), .an(an_b)
    );

    always #5 clk100MHz = ~clk100MHz;

    typedef struct {
        int         k;
        logic       lit;     // past the initial blank period: check all outputs
        logic [3:0] an_a;
        logic [3:0] an_b;
        logic [6:0] seg_a;
        logic [6:0] seg_b;
        logic       dp;
    } exp_t;

    exp_t       sb[$];
    int         k = 0;          // clock edges since reset release
    logic [3:0] snap [4];       // [0]=onesec .. [3]=tenmin
    int         errors = 0;
    int         checks = 0;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected display after kk edges: slot advances every RD edges, the blink phase
    // flips every BD edges, and nothing lights before one full frame has elapsed.
    function automatic exp_t expect_at(input int kk, input logic blink);
        exp_t       e;
        int         slot;
        int         phase;
        logic [3:0] d;
        logic [3:0] onehot;
        slot   = (kk / RD) % 4;
        phase  = (kk / BD) % 2;
        d      = snap[slot];
        onehot = 4'b0001 << slot;
        e.k     = kk;
        e.lit   = (kk >= FRAME);
        e.an_a  = 4'b1111;
        e.an_b  = 4'b1111;
        e.seg_a = 7'b1111111;
        e.seg_b = 7'b1111111;
        e.dp    = 1'b1;
        if (e.lit) begin
            e.an_b  = ~onehot;
            e.seg_b = dec(d);
            if (!(slot == 3 && d == 4'd0)) begin
                e.an_a  = e.an_b;
                e.seg_a = e.seg_b;
            end
            if (slot == 2 && (!blink || phase == 1)) e.dp = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int kk, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d: got %b expected %b", name, kk, act, exp);
        end
    endtask

    // Reference: one expected entry per clock edge out of reset.
    initial begin
        forever begin
            @(posedge clk100MHz);
            if (rst) begin
                k = 0;
                sb.delete();
            end else begin
                k++;
                if (k % FRAME == 0) begin
                    snap[0] = onesecout;
                    snap[1] = tensecout;
                    snap[2] = oneminout;
                    snap[3] = tenminout;
                end
                sb.push_back(expect_at(k, dp_blink));
            end
        end
    end

    // Monitor: compares on the falling edge, away from the update edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk100MHz);
            if (!rst && sb.size() > 0) begin
                e = sb.pop_front();
                chk("an_a", e.k, {4'b0, an_a}, {4'b0, e.an_a});
                chk("an_b", e.k, {4'b0, an_b}, {4'b0, e.an_b});
                if (e.lit) begin
                    chk("seg_a", e.k, {1'b0, seg_a}, {1'b0, e.seg_a});
                    chk("seg_b", e.k, {1'b0, seg_b}, {1'b0, e.seg_b});
                    chk("dp_a", e.k, {7'b0, dp_a}, {7'b0, e.dp});
                    chk("dp_b", e.k, {7'b0, dp_b}, {7'b0, e.dp});
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk100MHz);
        #2;
    endtask

    // Wait until the display is lit and one edge into the given slot (bounded).
    task automatic wait_slot(input int s);
        int  n;
        logic hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < 64) begin
            @(posedge clk100MHz);
            #2;
            n++;
            if (k >= FRAME && (k / RD) % 4 == s && k % RD == 1) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_slot%0d: slot not reached in 64 cycles", s);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an_a"},  k, {4'b0, an_a},  8'h0F);
        chk({tag, "_seg_a"}, k, {1'b0, seg_a}, 8'h7F);
        chk({tag, "_dp_a"},  k, {7'b0, dp_a},  8'h01);
        chk({tag, "_an_b"},  k, {4'b0, an_b},  8'h0F);
        chk({tag, "_seg_b"}, k, {1'b0, seg_b}, 8'h7F);
        chk({tag, "_dp_b"},  k, {7'b0, dp_b},  8'h01);
    endtask

    initial begin
        repeat (2) @(posedge clk100MHz);
        #1;
        chk_reset_outputs("rst_hold");
        @(posedge clk100MHz);
        #2;
        rst = 1'b0;

        // Digits 1,2,3,4 with a steady dot for three frames.
        cycles(3 * FRAME);

        // Tear check: onesec changes mid-frame, takes effect only at the next wrap.
        wait_slot(1);
        onesecout = 4'd7;
        cycles(2 * FRAME + 4);

        // Leading zero suppression with a non-blanked zero elsewhere.
        tenminout = 4'd0; oneminout = 4'd5; tensecout = 4'd0; onesecout = 4'd9;
        cycles(2 * FRAME + 4);

        // Non-BCD on the minutes digit.
        oneminout = 4'hC;
        cycles(2 * FRAME);

        // Blinking dot over several blink windows.
        dp_blink = 1'b1;
        cycles(5 * FRAME);

        // Random digits and dot mode changing at arbitrary times.
        repeat (400) begin
            cycles(1);
            if ($urandom_range(0, 3) == 0) begin
                tenminout = 4'($urandom_range(0, 15));
                oneminout = 4'($urandom_range(0, 15));
                tensecout = 4'($urandom_range(0, 15));
                onesecout = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) tenminout = 4'd0;
            end
            if ($urandom_range(0, 15) == 0) dp_blink = 1'($urandom_range(0, 1));
        end

        // Async reset in the middle of slot 2 blanks at once.
        dp_blink = 1'b0;
        wait_slot(2);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_async");
        cycles(2);
        rst = 1'b0;

        // Blank period repeats, then normal scanning resumes.
        cycles(3 * FRAME);

        @(negedge clk100MHz);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
